// File: rtl/axilite_pkg.sv
// Constants shared by the AXI-lite address sender and the responder-side capture blocks.
// Queue depth, its count width, and the default address width.
package axilite_pkg;

  localparam int AXILITE_ADDR_QDEPTH    = 2;
  localparam int AXILITE_ADDR_CNT_W     = $clog2(AXILITE_ADDR_QDEPTH + 1);
  localparam int AXILITE_ADDR_WIDTH_DEF = 32;

  typedef logic [AXILITE_ADDR_CNT_W-1:0] qcnt_t;

  // True when a queue of the given occupancy can take another entry.
  function automatic logic qcnt_has_space(input qcnt_t cnt);
    return cnt != qcnt_t'(AXILITE_ADDR_QDEPTH);
  endfunction

endpackage

// File: rtl/axilite_addr_queue.sv
// 2-entry address FIFO: a push is visible at the head after one edge; no pass-through when full.
// push_rdy depends only on the registered count; a push at count 2 is refused even alongside a pop.
module axilite_addr_queue
  import axilite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXILITE_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] push_dat,
  input  logic                  push_vld,
  output logic                  push_rdy,
  input  logic                  pop,
  output qcnt_t                 count,
  output qcnt_t                 count_nxt,
  output logic [ADDR_WIDTH-1:0] head_nxt
);

  logic [ADDR_WIDTH-1:0] mem [AXILITE_ADDR_QDEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  rd_ptr_nxt;
  logic                  push;
  logic                  pop_ok;

  assign push_rdy   = qcnt_has_space(count);
  assign push       = push_vld && push_rdy;
  assign pop_ok     = pop && (count != '0);
  assign rd_ptr_nxt = rd_ptr ^ pop_ok;

  always_comb begin
    count_nxt = count;
    case ({push, pop_ok})
      2'b10:   count_nxt = count + qcnt_t'(1);
      2'b01:   count_nxt = count - qcnt_t'(1);
      default: count_nxt = count;
    endcase
  end

  // The incoming word lands directly at the head when the queue was empty,
  // or when it holds one entry that is being popped this cycle.
  assign head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? push_dat : mem[rd_ptr_nxt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AXILITE_ADDR_QDEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/axilite_addr_sender.sv
// AXI-lite AW/AR initiator: queued address reaches registered valid/addr one edge after push; held until ready.
// req_ready drops at 2 queued entries; optional stall watchdog under AXILITE_ADDR_TIMEOUT_EN.
module axilite_addr_sender
  import axilite_pkg::*;
#(
`ifdef AXILITE_ADDR_TIMEOUT_EN
  parameter int TIMEOUT_WIDTH = 16,
`endif
  parameter int ADDR_WIDTH    = AXILITE_ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     valid,
  input  logic                     ready,
  output logic                     sent,
`ifdef AXILITE_ADDR_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  output logic                     timeout,
`endif
  output logic                     busy
);

  qcnt_t                 count;
  qcnt_t                 count_nxt;
  logic [ADDR_WIDTH-1:0] head_nxt;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  sent_q;
  logic                  handshake;

  assign handshake = valid_q && ready;

  axilite_addr_queue #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_dat  (req_addr),
    .push_vld  (req_valid),
    .push_rdy  (req_ready),
    .pop       (handshake),
    .count     (count),
    .count_nxt (count_nxt),
    .head_nxt  (head_nxt)
  );

  // valid/addr are loaded from the queue's next state so they match count
  // exactly while never looking at ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      valid_q <= (count_nxt != '0);
      if (count_nxt != '0) begin
        addr_q <= head_nxt;
      end
      sent_q <= handshake;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign sent  = sent_q;
  assign busy  = (count != '0);

`ifdef AXILITE_ADDR_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] stall_cnt;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt_nxt;
  logic                     timeout_q;
  logic                     stall;

  assign stall = valid_q && !ready;

  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (handshake) begin
      stall_cnt_nxt = '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt_nxt = stall_cnt + TIMEOUT_WIDTH'(1);
    end
  end

  // Flag only; the pending transfer stays on the bus regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (handshake) begin
        timeout_q <= 1'b0;
      end else if ((timeout_limit != '0) && (stall_cnt_nxt == timeout_limit)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_axilite_addr_sender.sv
// Bench for axilite_addr_sender: vector table plus scoreboard-driven sequences.
// Timeout checks are compiled in when AXILITE_ADDR_TIMEOUT_EN is defined.
module tb_axilite_addr_sender;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        valid;
  logic        ready;
  logic        sent;
  logic        busy;
`ifdef AXILITE_ADDR_TIMEOUT_EN
  logic [15:0] timeout_limit;
  logic        timeout;
`endif

  axilite_addr_sender dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr      (req_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .addr          (addr),
    .valid         (valid),
    .ready         (ready),
    .sent          (sent),
`ifdef AXILITE_ADDR_TIMEOUT_EN
    .timeout_limit (timeout_limit),
    .timeout       (timeout),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mq[$];
  logic        exp_sent;
  int          sent_seen;
  int          vld_cyc;

  typedef struct packed {
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        e_rr;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_sent;
    logic        e_busy;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic rdy,
                              input logic e_rr, input logic e_vld, input logic [31:0] e_addr,
                              input logic e_sent, input logic e_busy);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.e_rr = e_rr; v.e_vld = e_vld; v.e_addr = e_addr; v.e_sent = e_sent; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare DUT outputs against the scoreboard contents.
  task automatic check_now(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(mq.size() != 2));
    chk({tag, ".valid"},     32'(valid),     32'(mq.size() != 0));
    chk({tag, ".busy"},      32'(busy),      32'(mq.size() != 0));
    chk({tag, ".sent"},      32'(sent),      32'(exp_sent));
    if (mq.size() != 0) chk({tag, ".addr"}, addr, mq[0]);
    if (sent) sent_seen++;
    if (valid) vld_cyc++;
  endtask

  // Drive one cycle from the negedge, update the scoreboard for the edge, check at next negedge.
  task automatic step(input string tag, input logic rv, input logic [31:0] ra, input logic rdy);
    int  sz;
    logic hs;
    req_valid = rv;
    req_addr  = ra;
    ready     = rdy;
    sz = mq.size();
    hs = (sz != 0) && rdy;
    @(posedge clk);
    if (hs) void'(mq.pop_front());
    if (rv && (sz != 2)) mq.push_back(ra);
    exp_sent = hs;
    @(negedge clk);
    check_now(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    ready     = 1'b0;
    exp_sent  = 1'b0;
    sent_seen = 0;
    vld_cyc   = 0;
`ifdef AXILITE_ADDR_TIMEOUT_EN
    timeout_limit = 16'd0;
`endif

    //            rv    ra         rdy   rr    vld   addr       sent  busy
    vecs[0]  = mk(1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1);
    vecs[2]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 32'hA,    1'b0, 1'b1, 1'b1, 32'hA,    1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'hB,    1'b1, 1'b1);
    vecs[10] = mk(1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0);
    vecs[11] = mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0);

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    chk("rst.valid",     32'(valid),     32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.sent",      32'(sent),      32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.addr",      addr,           32'd0);
`ifdef AXILITE_ADDR_TIMEOUT_EN
    chk("rst.timeout",   32'(timeout),   32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Single address held under backpressure, then fill-and-stall ordering.
    for (int i = 0; i < 12; i++) begin
      req_valid = vecs[i].rv;
      req_addr  = vecs[i].ra;
      ready     = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
      chk($sformatf("vec%0d.valid", i),     32'(valid),     32'(vecs[i].e_vld));
      chk($sformatf("vec%0d.sent", i),      32'(sent),      32'(vecs[i].e_sent));
      chk($sformatf("vec%0d.busy", i),      32'(busy),      32'(vecs[i].e_busy));
      if (vecs[i].e_vld) chk($sformatf("vec%0d.addr", i), addr, vecs[i].e_addr);
    end

    // Streaming: one push and one handshake per cycle.
    sent_seen = 0;
    vld_cyc   = 0;
    for (int i = 0; i < 8; i++) begin
      step("stream", 1'b1, 32'h10 + 32'(i), 1'b1);
    end
    step("stream", 1'b0, 32'h0, 1'b1);
    step("stream", 1'b0, 32'h0, 1'b0);
    chk("stream.sent_pulses", 32'(sent_seen), 32'd8);
    chk("stream.valid_cycles", 32'(vld_cyc), 32'd8);
    chk("stream.drained", 32'(mq.size()), 32'd0);

    // Full queue with a simultaneous pop: the push is refused.
    step("full", 1'b1, 32'hD, 1'b0);
    step("full", 1'b1, 32'hE, 1'b0);
    chk("full.req_ready_low", 32'(req_ready), 32'd0);
    step("fullpop", 1'b1, 32'hF, 1'b1);
    chk("fullpop.head", addr, 32'hE);
    chk("fullpop.busy", 32'(busy), 32'd1);
    step("fullpop", 1'b0, 32'h0, 1'b1);
    chk("fullpop.empty", 32'(valid), 32'd0);
    step("fullpop", 1'b0, 32'h0, 1'b0);

    // Reset mid-operation with two entries queued.
    step("midrst", 1'b1, 32'h77, 1'b0);
    step("midrst", 1'b1, 32'h88, 1'b0);
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst.valid",     32'(valid),     32'd0);
    chk("midrst.busy",      32'(busy),      32'd0);
    chk("midrst.req_ready", 32'(req_ready), 32'd1);
    mq.delete();
    exp_sent = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step("postrst", 1'b0, 32'h0, 1'b1);
    step("postrst", 1'b0, 32'h0, 1'b1);

`ifdef AXILITE_ADDR_TIMEOUT_EN
    // Stall watchdog: limit 5, ready low.
    timeout_limit = 16'd5;
    step("tmo", 1'b1, 32'h55, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step("tmo", 1'b0, 32'h0, 1'b0);
      chk($sformatf("tmo.stall%0d", i), 32'(timeout), (i >= 5) ? 32'd1 : 32'd0);
    end
    step("tmo", 1'b0, 32'h0, 1'b1);
    chk("tmo.cleared", 32'(timeout), 32'd0);
    step("tmo", 1'b0, 32'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
